// File: rtl/cfg_bank.sv
// cfg_bank: config register bank with dirty tracking and handshake flush; CFG_BANK_READBACK_EN enables the read port
module cfg_bank #(
  parameter int NUM_REGS = 8,
  parameter int WORD_SIZE = 8,
  parameter logic [NUM_REGS*WORD_SIZE-1:0] DEFAULTS = '0,
  localparam int ADDR_W = $clog2(NUM_REGS) > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [NUM_REGS-1:0]  dirty
);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  typedef enum logic [1:0] {IDLE, SCAN, SEND} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] idx, idx_n, addr_q;
  logic [WORD_SIZE-1:0] data_q;
  logic [WORD_SIZE-1:0] regs [NUM_REGS];
  logic wr_ok, cap, hs;
  assign wr_ok = wr_en && ({1'b0, wr_addr} < LIM);
  assign out_valid = state == SEND && !rst;
  assign flush_busy = state != IDLE && !rst;
  assign out_addr = rst ? '0 : addr_q;
  assign out_data = rst ? '0 : data_q;
  assign hs = out_valid && out_ready;
  // register file and dirty flags; a write landing in the handshake cycle keeps its flag set
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= DEFAULTS[i*WORD_SIZE +: WORD_SIZE];
      dirty <= '1;
    end else begin
      if (hs) dirty[addr_q] <= 1'b0;
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
        dirty[wr_addr] <= 1'b1;
      end
    end
  // flush state, scan index and the captured beat held stable through SEND
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      if (cap) begin
        addr_q <= idx;
        data_q <= regs[idx];
      end
    end
  // flush sequencing: scan one index per cycle, emit each dirty register as one beat
  always_comb begin
    state_n = state;
    idx_n = idx;
    cap = 1'b0;
    case (state)
      IDLE: if (flush_req) begin
        state_n = SCAN;
        idx_n = '0;
      end
      SCAN: if (dirty[idx]) begin
        state_n = SEND;
        cap = 1'b1;
      end else begin
        state_n = idx == LAST ? IDLE : SCAN;
        idx_n = idx == LAST ? idx : idx + 1'b1;
      end
      SEND: if (out_ready) begin
        state_n = idx == LAST ? IDLE : SCAN;
        idx_n = idx == LAST ? idx : idx + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
`ifdef CFG_BANK_READBACK_EN
  logic rd_ok, rd_valid_q;
  logic [WORD_SIZE-1:0] rd_data_q;
  assign rd_ok = {1'b0, rd_addr} < LIM;
  assign rd_valid = rd_valid_q && !rst;
  assign rd_data = rst ? '0 : rd_data_q;
  // one-cycle registered read; sees the pre-write value on a same-address collision
  always_ff @(posedge clk)
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_valid_q <= rd_en;
      rd_data_q <= rd_en && rd_ok ? regs[rd_addr] : '0;
    end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_en, rd_addr};
  assign rd_valid = 1'b0;
  assign rd_data = '0;
`endif
endmodule
